// File: rtl/ft_pkg.sv
// Shared types and constants for the registered feedthrough skid buffer.
`timescale 1ns/1ps
package ft_pkg;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned COUNT_W       = 2;

  // Encoding doubles as the occupancy count; 2'd3 is unreachable and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/ft_data_reg.sv
// WIDTH-bit enable register with synchronous active-low reset to RESET_DATA.
`timescale 1ns/1ps
module ft_data_reg #(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RESET_DATA;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ft_skid_buffer.sv
// Two-entry valid/ready pipeline break; all handshake outputs come straight from flops.
`timescale 1ns/1ps
module ft_skid_buffer
  import ft_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
);

  state_t           state;
  state_t           state_nx;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; handshake outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != TWO);
      count     <= COUNT_W'(state_nx);
    end
  end

  // Next-state and data-register load selection.
  always_comb begin
    state_nx = state;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_d   = in_data;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx = ONE;
          main_en  = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_nx = TWO;
          skid_en  = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        main_d = skid_q;
        if (out_fire) begin
          state_nx = ONE;
          main_en  = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  ft_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  ft_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_ft_skid_buffer.sv
// Bench for ft_skid_buffer: queue-based occupancy model for WIDTH 8/1/64 plus directed literal checks.
`timescale 1ns/1ps
module tb_ft_skid_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic       iv8 = 1'b0, or8 = 1'b0, ir8, ov8;
  logic [7:0] id8 = '0, od8;
  logic [1:0] cnt8;

  logic       iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
  logic [0:0] id1 = '0, od1;
  logic [1:0] cnt1;

  logic        iv64 = 1'b0, or64 = 1'b0, ir64, ov64;
  logic [63:0] id64 = '0, od64;
  logic [1:0]  cnt64;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [63:0] q8[$];
  logic [63:0] q1[$];
  logic [63:0] q64[$];

  ft_skid_buffer #(.WIDTH(8), .RESET_DATA(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .count(cnt8));

  ft_skid_buffer #(.WIDTH(1), .RESET_DATA(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1));

  ft_skid_buffer #(.WIDTH(64), .RESET_DATA(64'h0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .count(cnt64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of capacity 2 whose handshakes follow from its own occupancy.
  always @(posedge clk) begin
    bit f_in, f_out;
    if (!rst_n) begin
      q8.delete(); q1.delete(); q64.delete();
      chk_en = 1'b1;
    end else begin
      f_in  = iv8 && (q8.size() < 2);
      f_out = or8 && (q8.size() > 0);
      if (f_out) void'(q8.pop_front());
      if (f_in)  q8.push_back(64'(id8));
      f_in  = iv1 && (q1.size() < 2);
      f_out = or1 && (q1.size() > 0);
      if (f_out) void'(q1.pop_front());
      if (f_in)  q1.push_back(64'(id1));
      f_in  = iv64 && (q64.size() < 2);
      f_out = or64 && (q64.size() > 0);
      if (f_out) void'(q64.pop_front());
      if (f_in)  q64.push_back(id64);
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("w8_count",     64'(cnt8),  64'(q8.size()));
      chk("w8_in_ready",  64'(ir8),   64'(q8.size() < 2));
      chk("w8_out_valid", 64'(ov8),   64'(q8.size() > 0));
      if (q8.size() > 0) chk("w8_out_data", 64'(od8), q8[0]);
      chk("w1_count",     64'(cnt1),  64'(q1.size()));
      chk("w1_in_ready",  64'(ir1),   64'(q1.size() < 2));
      chk("w1_out_valid", 64'(ov1),   64'(q1.size() > 0));
      if (q1.size() > 0) chk("w1_out_data", 64'(od1), q1[0]);
      chk("w64_count",     64'(cnt64), 64'(q64.size()));
      chk("w64_in_ready",  64'(ir64),  64'(q64.size() < 2));
      chk("w64_out_valid", 64'(ov64),  64'(q64.size() > 0));
      if (q64.size() > 0) chk("w64_out_data", od64, q64[0]);
    end
  end

  // Wide and narrow instances see random traffic for the whole run.
  always @(negedge clk) begin
    iv1  = ($urandom_range(0, 3) != 0);
    or1  = ($urandom_range(0, 1) != 0);
    id1  = 1'($urandom);
    iv64 = ($urandom_range(0, 3) != 0);
    or64 = ($urandom_range(0, 2) == 0);
    id64 = {$urandom, $urandom};
  end

  initial begin
    // Reset with a word pending on the input: nothing may be captured.
    rst_n = 1'b0; iv8 = 1'b1; id8 = 8'hAA; or8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; iv8 = 1'b0;
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_in_ready",  64'(ir8), 64'd1);
    chk("rst_count",     64'(cnt8), 64'd0);
    chk("rst_out_data",  64'(od8), 64'h00);
    @(negedge clk);
    chk("rst_no_capture", 64'(cnt8), 64'd0);

    // Single transfer with one cycle of latency.
    iv8 = 1'b1; id8 = 8'h5A; or8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    chk("single_valid", 64'(ov8), 64'd1);
    chk("single_data",  64'(od8), 64'h5A);
    @(negedge clk);
    chk("single_gone",  64'(ov8), 64'd0);

    // Fill to two entries under backpressure, then drain in order.
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h01;
    @(negedge clk);
    chk("fill_count1", 64'(cnt8), 64'd1);
    id8 = 8'h02;
    @(negedge clk);
    chk("fill_count2", 64'(cnt8), 64'd2);
    chk("fill_full",   64'(ir8),  64'd0);
    id8 = 8'h03;
    @(negedge clk);
    chk("fill_hold_cnt",  64'(cnt8), 64'd2);
    chk("fill_hold_data", 64'(od8),  64'h01);
    or8 = 1'b1;
    @(negedge clk);
    chk("drain_first",  64'(od8),  64'h02);
    chk("drain_cnt",    64'(cnt8), 64'd1);
    chk("drain_ready",  64'(ir8),  64'd1);
    @(negedge clk);
    iv8 = 1'b0;
    chk("drain_third",  64'(od8),  64'h03);
    chk("drain_cnt3",   64'(cnt8), 64'd1);
    @(negedge clk);
    chk("drain_empty",  64'(ov8),  64'd0);

    // Streaming: one word per cycle, occupancy pinned at one.
    or8 = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk("stream_data",  64'(od8),  64'(i - 1));
        chk("stream_count", 64'(cnt8), 64'd1);
      end
      iv8 = (i < 16);
      id8 = 8'(i);
      @(negedge clk);
    end
    chk("stream_done", 64'(ov8), 64'd0);

    // Reset while full; old contents must never reappear.
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h11;
    @(negedge clk);
    id8 = 8'h22;
    @(negedge clk);
    iv8 = 1'b0;
    chk("mid_full", 64'(cnt8), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_count", 64'(cnt8), 64'd0);
    chk("mid_valid", 64'(ov8),  64'd0);
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h33;
    @(negedge clk);
    iv8 = 1'b0;
    chk("mid_new_data", 64'(od8), 64'h33);
    @(negedge clk);
    chk("mid_no_stale", 64'(ov8), 64'd0);

    // Random valid/ready traffic on the 8-bit instance as well.
    for (int c = 0; c < 10000; c++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      or8 = ($urandom_range(0, 1) != 0);
      id8 = 8'($urandom);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
